// File: rtl/nanosoc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// nanosoc_reset_sequencer
//
// Purpose:
//   Merges system reset requests (CPU, watchdog, lockup, PMU/debug) and drives
//   a staged reset of the nanosoc domains: both domains are held in reset,
//   then the AHB (HCLK) domain is released, and after a gap the APB domain is
//   released. A sticky cause register records why the system was reset.
//
// Ports:
//   SYS_FCLK            in   free-running system clock (only clock)
//   SYS_PORESET         in   power-on reset, asynchronous, active-high
//   CPU_SYSRESETREQ     in   CPU system reset request (level)
//   SYS_WDOGRESETREQ    in   watchdog reset request (level)
//   CPU_LOCKUP          in   processor locked up
//   SYS_LOCKUPRESET     in   config: treat lockup as a reset request
//   SYS_PMUDBGRESETREQ  in   PMU/debug reset request (level)
//   RSTINFO_CLR         in   single-cycle pulse clearing the cause register
//   SYS_HRESETn_REQ     out  AHB-domain reset request, active-low
//   SYS_PRESETn_REQ     out  APB-domain reset request, active-low
//   SYS_RSTACTIVE       out  high while any stage is still in reset
//   SYS_RSTINFO         out  sticky cause {DBG, LOCKUP, WDOG, SYSRESETREQ, POR}
// -----------------------------------------------------------------------------
module nanosoc_reset_sequencer #(
    parameter int HOLD_CYCLES = 16,  // 1..2**CNT_W
    parameter int STAGE_GAP   = 4,   // 1..2**CNT_W
    parameter int CNT_W       = 8
) (
    input  logic       SYS_FCLK,
    input  logic       SYS_PORESET,
    input  logic       CPU_SYSRESETREQ,
    input  logic       SYS_WDOGRESETREQ,
    input  logic       CPU_LOCKUP,
    input  logic       SYS_LOCKUPRESET,
    input  logic       SYS_PMUDBGRESETREQ,
    input  logic       RSTINFO_CLR,
    output logic       SYS_HRESETn_REQ,
    output logic       SYS_PRESETn_REQ,
    output logic       SYS_RSTACTIVE,
    output logic [4:0] SYS_RSTINFO
);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,   // both domains held in reset
        ST_REL_H  = 2'd1,   // AHB domain released, APB still in reset
        ST_RUN    = 2'd2    // both domains running
    } state_t;

    // Counter reload values; the counter counts down to zero, so a hold of
    // N cycles loads N-1.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hresetn_q, hresetn_d;
    logic             presetn_q, presetn_d;
    logic             rstactive_q, rstactive_d;
    logic [4:0]       rstinfo_q, rstinfo_d;

    logic [3:0]       req;
    logic             any_req;

    assign req     = {SYS_PMUDBGRESETREQ, CPU_LOCKUP & SYS_LOCKUPRESET,
                      SYS_WDOGRESETREQ, CPU_SYSRESETREQ};
    assign any_req = |req;

    // Next-state logic. Outputs are derived from the next state and then
    // registered, so a request sampled on an edge reaches the pins right after
    // that edge with no combinational path from the request inputs.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_ASSERT: begin
                if (any_req) begin
                    // A held request keeps restarting the hold window.
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_REL_H;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_REL_H: begin
                if (any_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (any_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = HOLD_LOAD;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = HOLD_LOAD;
            end
        endcase

        hresetn_d   = (state_d != ST_ASSERT);
        presetn_d   = (state_d == ST_RUN);
        rstactive_d = (state_d != ST_RUN);

        // Clear first, then OR in this cycle's causes so a simultaneous set
        // wins bit by bit. Bit 0 (POR) is only ever set by the reset below.
        rstinfo_d = RSTINFO_CLR ? 5'b00000 : rstinfo_q;
        rstinfo_d = rstinfo_d | {req, 1'b0};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge SYS_FCLK or posedge SYS_PORESET) begin
        if (SYS_PORESET) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= HOLD_LOAD;
            hresetn_q   <= 1'b0;
            presetn_q   <= 1'b0;
            rstactive_q <= 1'b1;
            rstinfo_q   <= 5'b00001;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hresetn_q   <= hresetn_d;
            presetn_q   <= presetn_d;
            rstactive_q <= rstactive_d;
            rstinfo_q   <= rstinfo_d;
        end
    end

    assign SYS_HRESETn_REQ = hresetn_q;
    assign SYS_PRESETn_REQ = presetn_q;
    assign SYS_RSTACTIVE   = rstactive_q;
    assign SYS_RSTINFO     = rstinfo_q;

endmodule

// File: tb/tb_nanosoc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nanosoc_reset_sequencer
//
// Directed bench for nanosoc_reset_sequencer (HOLD_CYCLES=16, STAGE_GAP=4).
// Each step drives inputs, pushes the outputs expected after the next
// SYS_FCLK edge onto a scoreboard queue, then pops and compares them 1 ns
// after that edge.
// -----------------------------------------------------------------------------
module tb_nanosoc_reset_sequencer;

    localparam int HOLD = 16;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       poreset;
    logic       cpu_req, wdog_req, lockup, lockup_cfg, dbg_req, info_clr;
    logic       hresetn, presetn, rstactive;
    logic [4:0] rstinfo;

    typedef struct {
        string      tag;
        logic       h;
        logic       p;
        logic       a;
        logic [4:0] info;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    nanosoc_reset_sequencer #(
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP),
        .CNT_W       (8)
    ) dut (
        .SYS_FCLK           (clk),
        .SYS_PORESET        (poreset),
        .CPU_SYSRESETREQ    (cpu_req),
        .SYS_WDOGRESETREQ   (wdog_req),
        .CPU_LOCKUP         (lockup),
        .SYS_LOCKUPRESET    (lockup_cfg),
        .SYS_PMUDBGRESETREQ (dbg_req),
        .RSTINFO_CLR        (info_clr),
        .SYS_HRESETn_REQ    (hresetn),
        .SYS_PRESETn_REQ    (presetn),
        .SYS_RSTACTIVE      (rstactive),
        .SYS_RSTINFO        (rstinfo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected RSTACTIVE follows from the domain outputs: only RUN has both high.
    task automatic push(input string tag, input logic h, input logic p, input logic [4:0] info);
        exp_t e;
        e.tag  = tag;
        e.h    = h;
        e.p    = p;
        e.a    = !(h && p);
        e.info = info;
        sb_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".hresetn"},   {4'b0, hresetn},   {4'b0, e.h});
            check({e.tag, ".presetn"},   {4'b0, presetn},   {4'b0, e.p});
            check({e.tag, ".rstactive"}, {4'b0, rstactive}, {4'b0, e.a});
            check({e.tag, ".rstinfo"},   rstinfo,           e.info);
        end
    endtask

    // One clock: expectation for the state after the coming edge.
    task automatic step(input string tag, input logic h, input logic p, input logic [4:0] info);
        push(tag, h, p, info);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // A release sequence counted from the edge that last saw a request:
    // HRESETn rises after edge HOLD, PRESETn after edge HOLD+GAP.
    task automatic release_seq(input string tag, input logic [4:0] info);
        for (int i = 1; i <= HOLD + GAP; i++)
            step(tag, i >= HOLD, i >= HOLD + GAP, info);
    endtask

    initial begin
        poreset    = 1'b1;
        cpu_req    = 1'b0;
        wdog_req   = 1'b0;
        lockup     = 1'b0;
        lockup_cfg = 1'b0;
        dbg_req    = 1'b0;
        info_clr   = 1'b0;

        // Reset values held while SYS_PORESET is high.
        #2;
        push("reset_async", 1'b0, 1'b0, 5'b00001);
        compare_front();
        step("reset_held", 1'b0, 1'b0, 5'b00001);
        step("reset_held", 1'b0, 1'b0, 5'b00001);

        // POR release: 16-edge hold, then 4-edge gap.
        poreset = 1'b0;
        release_seq("por", 5'b00001);
        step("por_run", 1'b1, 1'b1, 5'b00001);

        // One-cycle watchdog pulse from RUN.
        wdog_req = 1'b1;
        step("wdog_hit", 1'b0, 1'b0, 5'b00101);
        wdog_req = 1'b0;
        release_seq("wdog", 5'b00101);

        // Request held for 40 cycles stalls the sequence.
        cpu_req = 1'b1;
        for (int i = 0; i < 40; i++)
            step("sysreq_held", 1'b0, 1'b0, 5'b00111);
        cpu_req = 1'b0;
        release_seq("sysreq", 5'b00111);

        // Lockup without the reset-on-lockup config does nothing.
        lockup = 1'b1;
        for (int i = 0; i < 5; i++)
            step("lockup_off", 1'b1, 1'b1, 5'b00111);
        // With the config set, lockup triggers a full sequence.
        lockup_cfg = 1'b1;
        step("lockup_hit", 1'b0, 1'b0, 5'b01111);
        lockup     = 1'b0;
        lockup_cfg = 1'b0;
        release_seq("lockup", 5'b01111);

        // Debug request in the 2nd REL_H cycle aborts the APB release.
        wdog_req = 1'b1;
        step("dbg_pre", 1'b0, 1'b0, 5'b01111);
        wdog_req = 1'b0;
        for (int i = 1; i <= HOLD + 1; i++)
            step("dbg_pre", i >= HOLD, 1'b0, 5'b01111);
        dbg_req = 1'b1;
        step("dbg_hit", 1'b0, 1'b0, 5'b11111);
        dbg_req = 1'b0;
        release_seq("dbg_restart", 5'b11111);

        // Clear together with a new cause: the set wins, POR bit is cleared.
        info_clr = 1'b1;
        cpu_req  = 1'b1;
        step("clr_set", 1'b0, 1'b0, 5'b00010);
        info_clr = 1'b0;
        cpu_req  = 1'b0;
        for (int i = 0; i < 5; i++)
            step("mid_hold", 1'b0, 1'b0, 5'b00010);

        // Power-on reset mid-hold acts immediately and restarts the hold.
        poreset = 1'b1;
        #1;
        push("por_mid_async", 1'b0, 1'b0, 5'b00001);
        compare_front();
        step("por_mid_held", 1'b0, 1'b0, 5'b00001);
        poreset = 1'b0;
        release_seq("por_mid", 5'b00001);

        // Request on the last ASSERT cycle (cnt==0) blocks the release.
        wdog_req = 1'b1;
        step("late_pre", 1'b0, 1'b0, 5'b00101);
        wdog_req = 1'b0;
        for (int i = 1; i < HOLD; i++)
            step("late_pre", 1'b0, 1'b0, 5'b00101);
        cpu_req = 1'b1;
        step("late_hit", 1'b0, 1'b0, 5'b00111);
        cpu_req = 1'b0;
        release_seq("late", 5'b00111);

        // Simultaneous requests: every cause bit set, one sequence.
        info_clr   = 1'b1;
        cpu_req    = 1'b1;
        wdog_req   = 1'b1;
        lockup     = 1'b1;
        lockup_cfg = 1'b1;
        dbg_req    = 1'b1;
        step("multi_hit", 1'b0, 1'b0, 5'b11110);
        info_clr   = 1'b0;
        cpu_req    = 1'b0;
        wdog_req   = 1'b0;
        lockup     = 1'b0;
        lockup_cfg = 1'b0;
        dbg_req    = 1'b0;
        release_seq("multi", 5'b11110);
        step("multi_run", 1'b1, 1'b1, 5'b11110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Backstop so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
